// File: rtl/overcooked_pkg.sv
// Shared object codes, facing directions and grid dimensions for the kitchen grid.
package overcooked_pkg;

  localparam int unsigned GRID_COLS = 13;
  localparam int unsigned GRID_ROWS = 8;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [3:0] {
    G_EMPTY         = 4'd0,
    G_ONION_WHOLE   = 4'd1,
    G_ONION_CHOPPED = 4'd2,
    G_BOWL_EMPTY    = 4'd3,
    G_BOWL_FULL     = 4'd4,
    G_POT_EMPTY     = 4'd5,
    G_POT_RAW       = 4'd6,
    G_POT_COOKED    = 4'd7,
    G_POT_FIRE      = 4'd8,
    G_FIRE          = 4'd9,
    G_EXTINGUISHER  = 4'd10
  } obj_e;

endpackage

// File: rtl/check_in_front.sv
// Registered lookup of the grid cell the player faces, with bounds detection.
module check_in_front
  import overcooked_pkg::*;
#(
  parameter int unsigned GRID_W = GRID_COLS,
  parameter int unsigned GRID_H = GRID_ROWS
) (
  input  logic                               clk_in,
  input  logic                               rstn_in,
  input  logic [1:0]                         player_direction,
  input  logic [3:0]                         grid_x,
  input  logic [2:0]                         grid_y,
  input  logic [GRID_H-1:0][GRID_W-1:0][3:0] object_grid,
  output logic [3:0]                         object,
  output logic [3:0]                         front_x,
  output logic [2:0]                         front_y,
  output logic                               in_bounds
);

  localparam logic [4:0] W_EXT = 5'(GRID_W);
  localparam logic [3:0] H_EXT = 4'(GRID_H);

  logic [4:0] nx;
  logic [3:0] ny;
  logic       pos_ok;
  logic       hit;

  logic [3:0] object_d, object_q;
  logic [3:0] front_x_d, front_x_q;
  logic [2:0] front_y_d, front_y_q;
  logic       in_bounds_d, in_bounds_q;

  // One extra bit so x-1 at 0 becomes all-ones and fails the range check.
  always_comb begin
    nx = {1'b0, grid_x};
    ny = {1'b0, grid_y};
    case (player_direction)
      DIR_LEFT:  nx = {1'b0, grid_x} - 5'd1;
      DIR_RIGHT: nx = {1'b0, grid_x} + 5'd1;
      DIR_UP:    ny = {1'b0, grid_y} - 4'd1;
      DIR_DOWN:  ny = {1'b0, grid_y} + 4'd1;
      default: ;
    endcase
  end

  assign pos_ok = ({1'b0, grid_x} < W_EXT) && ({1'b0, grid_y} < H_EXT);
  assign hit    = pos_ok && (nx < W_EXT) && (ny < H_EXT);

  always_comb begin
    object_d    = G_EMPTY;
    front_x_d   = grid_x;
    front_y_d   = grid_y;
    in_bounds_d = 1'b0;
    if (hit) begin
      object_d    = object_grid[ny[2:0]][nx[3:0]];
      front_x_d   = nx[3:0];
      front_y_d   = ny[2:0];
      in_bounds_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      object_q    <= '0;
      front_x_q   <= '0;
      front_y_q   <= '0;
      in_bounds_q <= 1'b0;
    end else begin
      object_q    <= object_d;
      front_x_q   <= front_x_d;
      front_y_q   <= front_y_d;
      in_bounds_q <= in_bounds_d;
    end
  end

  assign object    = object_q;
  assign front_x   = front_x_q;
  assign front_y   = front_y_q;
  assign in_bounds = in_bounds_q;

endmodule

// File: tb/tb_check_in_front.sv
// Directed and randomized checks of the faced-cell lookup through a result scoreboard.
module tb_check_in_front;
  import overcooked_pkg::*;

  typedef struct {
    logic [3:0] obj;
    logic [3:0] fx;
    logic [2:0] fy;
    logic       inb;
    string      tag;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [1:0]             dir = 2'd0;
  logic [3:0]             gx = '0;
  logic [2:0]             gy = '0;
  logic [7:0][12:0][3:0]  grid = '0;
  logic [3:0]             object;
  logic [3:0]             front_x;
  logic [2:0]             front_y;
  logic                   in_bounds;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  check_in_front #(.GRID_W(13), .GRID_H(8)) dut (
    .clk_in(clk),
    .rstn_in(rstn),
    .player_direction(dir),
    .grid_x(gx),
    .grid_y(gy),
    .object_grid(grid),
    .object(object),
    .front_x(front_x),
    .front_y(front_y),
    .in_bounds(in_bounds)
  );

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1 entries");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    assert (object === e.obj) else begin
      n_err++;
      $error("FAIL %s.object observed=%0d expected=%0d", e.tag, object, e.obj);
    end
    n_cmp++;
    assert (front_x === e.fx) else begin
      n_err++;
      $error("FAIL %s.front_x observed=%0d expected=%0d", e.tag, front_x, e.fx);
    end
    n_cmp++;
    assert (front_y === e.fy) else begin
      n_err++;
      $error("FAIL %s.front_y observed=%0d expected=%0d", e.tag, front_y, e.fy);
    end
    n_cmp++;
    assert (in_bounds === e.inb) else begin
      n_err++;
      $error("FAIL %s.in_bounds observed=%0d expected=%0d", e.tag, in_bounds, e.inb);
    end
  endtask

  // Drive one cycle of stimulus, record what should appear, compare after the edge.
  task automatic step(input logic r, input int x, input int y, input dir_e d,
                      input int eo, input int ex, input int ey, input int eb,
                      input string tag);
    exp_t e;
    @(negedge clk);
    rstn = r;
    gx   = 4'(x);
    gy   = 3'(y);
    dir  = d;
    e.obj = 4'(eo); e.fx = 4'(ex); e.fy = 3'(ey); e.inb = eb[0]; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Independent reference using signed integers over the current grid.
  task automatic step_model(input int x, input int y, input dir_e d, input string tag);
    int fx, fy;
    fx = x; fy = y;
    if (d == DIR_LEFT)  fx = x - 1;
    if (d == DIR_RIGHT) fx = x + 1;
    if (d == DIR_UP)    fy = y - 1;
    if (d == DIR_DOWN)  fy = y + 1;
    if (x < 13 && fx >= 0 && fx < 13 && fy >= 0 && fy < 8)
      step(1'b1, x, y, d, int'(grid[fy][fx]), fx, fy, 1, tag);
    else
      step(1'b1, x, y, d, 0, x, y, 0, tag);
  endtask

  initial begin
    grid[2][0]  = 4'd1;
    grid[3][0]  = 4'd1;
    grid[6][12] = 4'd3;
    for (int i = 8; i <= 11; i++) grid[0][i] = 4'd5;

    step(1'b0, 1, 2, DIR_LEFT, 0, 0, 0, 0, "reset");
    step(1'b1, 1, 2, DIR_LEFT,  1, 0, 2, 1, "left_hit");
    step(1'b1, 1, 2, DIR_RIGHT, 0, 2, 2, 1, "right_empty");
    step(1'b1, 11, 6, DIR_RIGHT, 3, 12, 6, 1, "right_edge_col");
    step(1'b1, 9, 1, DIR_UP,    5, 9, 0, 1, "up_pot");
    step(1'b1, 0, 2, DIR_LEFT,  0, 0, 2, 0, "left_oob");
    step(1'b1, 12, 7, DIR_DOWN, 0, 12, 7, 0, "down_oob");
    step(1'b1, 12, 6, DIR_RIGHT, 0, 12, 6, 0, "right_oob");
    step(1'b1, 3, 0, DIR_UP,    0, 3, 0, 0, "up_oob");
    step(1'b1, 0, 3, DIR_UP,    1, 0, 2, 1, "up_hit");
    step(1'b1, 0, 2, DIR_DOWN,  1, 0, 3, 1, "down_hit");
    step(1'b1, 12, 0, DIR_DOWN, 0, 12, 1, 1, "down_corner");
    step(1'b1, 10, 1, DIR_UP,   5, 10, 0, 1, "up_pot2");
    step(1'b1, 14, 3, DIR_LEFT, 0, 14, 3, 0, "bad_x14");
    step(1'b1, 15, 7, DIR_UP,   0, 15, 7, 0, "bad_x15");
    step(1'b1, 13, 0, DIR_LEFT, 0, 13, 0, 0, "bad_x13");

    grid[5][6] = 4'd9;
    step(1'b1, 5, 5, DIR_RIGHT, 9, 6, 5, 1, "grid_fire");
    grid[5][6] = 4'd10;
    step(1'b1, 5, 5, DIR_RIGHT, 10, 6, 5, 1, "grid_change");

    step(1'b0, 9, 1, DIR_UP, 0, 0, 0, 0, "mid_reset");
    step(1'b1, 9, 1, DIR_UP, 5, 9, 0, 1, "post_reset");

    for (int n = 0; n < 40; n++) begin
      for (int yy = 0; yy < 8; yy++)
        for (int xx = 0; xx < 13; xx++)
          grid[yy][xx] = 4'($urandom_range(0, 10));
      step_model($urandom_range(0, 15), $urandom_range(0, 7),
                 dir_e'($urandom_range(0, 3)), "random");
    end

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/check_in_front.md
CHECK_IN_FRONT -- requirements
Module: check_in_front

Interface
REQ-001 The block SHALL have parameter GRID_W, default 13, meaning grid columns (x range 0..12).
REQ-002 The block SHALL have parameter GRID_H, default 8, meaning grid rows (y range 0..7).
REQ-003 The block SHALL have port clk_in, input, 1 bit, meaning the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn_in, input, 1 bit, meaning reset; reset is synchronous and active-low.
REQ-005 The block SHALL have port player_direction, input, 2 bits, meaning facing: LEFT=0, RIGHT=1, UP=2, DOWN=3.
REQ-006 The block SHALL have port grid_x, input, 4 bits, meaning player column.
REQ-007 The block SHALL have port grid_y, input, 3 bits, meaning player row.
REQ-008 The block SHALL have port object_grid, input, [7:0][12:0][3:0], meaning the 4-bit object code per cell, indexed [y][x].
REQ-009 The block SHALL have port object, output, 4 bits, meaning the object code in the cell the player faces.
REQ-010 The block SHALL have port front_x, output, 4 bits, meaning the faced column.
REQ-011 The block SHALL have port front_y, output, 3 bits, meaning the faced row.
REQ-012 The block SHALL have port in_bounds, output, 1 bit, meaning the faced cell lies inside the grid.

Function
REQ-013 Faced cell SHALL be: LEFT (x-1,y); RIGHT (x+1,y); UP (x,y-1); DOWN (x,y+1).
REQ-014 All outputs SHALL be registered, reflecting inputs sampled on the previous rising edge (latency exactly 1 cycle, new result every cycle, no handshake).
REQ-015 When the faced cell is in range (0..GRID_W-1, 0..GRID_H-1), object SHALL equal object_grid[front_y][front_x] and in_bounds SHALL be 1.
REQ-016 LEFT at x=0, UP at y=0, RIGHT at x=GRID_W-1, and DOWN at y=GRID_H-1 SHALL give in_bounds=0, object=0 (G_EMPTY), front_x=grid_x, front_y=grid_y; no wrap-around.
REQ-017 An invalid player position (grid_x >= GRID_W) SHALL give in_bounds=0, object=0, front_x=grid_x, front_y=grid_y.
REQ-018 Arithmetic SHALL be done one bit wider than each coordinate so underflow and overflow are detected, never truncated.
REQ-019 Changes to object_grid alone (position and direction held) SHALL appear on object after one cycle.

Reset
REQ-020 While rstn_in=0 at a rising edge, the block SHALL set object=0, front_x=0, front_y=0, in_bounds=0.
REQ-021 Reset SHALL take priority over input sampling; the first valid result SHALL appear one cycle after rstn_in returns high.

Structure
REQ-022 Object codes SHALL live in a shared package overcooked_pkg: G_EMPTY=0, G_ONION_WHOLE=1, G_ONION_CHOPPED=2, G_BOWL_EMPTY=3, G_BOWL_FULL=4, G_POT_EMPTY=5, G_POT_RAW=6, G_POT_COOKED=7, G_POT_FIRE=8, G_FIRE=9, G_EXTINGUISHER=10.
REQ-023 Direction codes LEFT, RIGHT, UP and DOWN, and the grid dimensions, SHALL also live in overcooked_pkg.
REQ-024 The design SHALL be a single module (combinational neighbour/bounds logic plus one output register stage) with no sub-module.

Verification
REQ-025 Grid all 0 except [2][0]=1, [3][0]=1, [6][12]=3, [0][8..11]=5; x=1, y=2, LEFT -> next cycle object=1, front=(0,2), in_bounds=1.
REQ-026 Same grid, x=1, y=2, RIGHT -> object=0, front=(2,2), in_bounds=1.
REQ-027 Same grid, x=11, y=6, RIGHT -> object=3, front=(12,6), in_bounds=1.
REQ-028 Same grid, x=9, y=1, UP -> object=5, front=(9,0); then x=0, y=2, LEFT -> object=0, in_bounds=0, front=(0,2).
REQ-029 Same grid, x=12, y=7, DOWN -> in_bounds=0, object=0; x=14 with any direction -> in_bounds=0, object=0.
REQ-030 Assert rstn_in=0 mid-stream with a valid hit pending -> all outputs 0 next cycle; release -> correct result one cycle later.
